spi_reg_bridge: RTL and testbench

SPI mode-0 slave that gives an external host read/write access to the 16 x 16-bit PID register file. Sits directly upstream of the register memory: drives its write_enable/w_addr/w_data/r_addr and consumes its registered r_data_o. Fully synchronous to clk_in; SPI pins are oversampled, and no logic is clocked by sclk.

---
 rtl/pid_regs_pkg.sv | 31 +++
 rtl/spi_sync_edge.sv | 55 +++++
 rtl/spi_reg_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pid_regs_pkg.sv
// Shared definitions for the SPI register bridge in front of the PID register file.
// Holds the register map, the command byte layout and the bridge FSM encoding.
package pid_regs_pkg;

    // Register map of the 16 x 16-bit PID register file
    localparam int unsigned REG_P     = 0;
    localparam int unsigned REG_I     = 1;
    localparam int unsigned REG_D     = 2;
    localparam int unsigned REG_SP    = 3;
    localparam int unsigned REG_PID_O = 14;
    localparam int unsigned REG_PWM_O = 15;

    // Command byte layout: {W, rsvd[2:0], addr[3:0]}
    localparam int unsigned CMD_W_BIT   = 7;
    localparam int unsigned CMD_RSVD_HI = 6;
    localparam int unsigned CMD_RSVD_LO = 4;
    localparam int unsigned CMD_ADDR_HI = 3;
    localparam int unsigned CMD_ADDR_LO = 0;
    localparam int unsigned CMD_ADDR_W  = CMD_ADDR_HI - CMD_ADDR_LO + 1;
    localparam int unsigned CMD_BITS    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRdFetch,
        StRdShift,
        StWrShift,
        StDone
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises the asynchronous SPI pins into the clk_in domain and produces
// single-cycle edge pulses for sclk and cs_n.
// Ports:
//   clk_in, reset          system clock, async active-low reset
//   sclk, cs_n, mosi       raw SPI pins
//   sclk_rise, sclk_fall   one-cycle pulses per synchronised sclk edge
//   cs_rise, cs_fall       one-cycle pulses per synchronised cs_n edge
//   cs_n_s, mosi_s         synchronised cs_n / mosi levels
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    // cs_n resets high so a deasserted select does not look like a falling edge
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave giving a host read/write access to the PID register file.
// Frame: command byte {W, rsvd[2:0], addr[3:0]} followed by a 16-bit data word,
// MSB first. Everything runs on clk_in; the SPI pins are oversampled.
// Ports:
//   clk_in, reset       system clock (>= 8x sclk), async active-low reset
//   sclk, cs_n, mosi    SPI inputs from the host
//   miso                SPI output to the host, 0 outside a read data phase
//   write_enable        one-cycle write strobe with w_addr / w_data
//   r_addr, r_data_i    read address out, registered read data back (1 clk later)
//   frame_err           one-cycle pulse on aborted or malformed frame
module spi_reg_bridge
    import pid_regs_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              write_enable,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [DATA_W-1:0] r_data_i,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CMD_BIT  = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] WR_COMMIT     = CNT_W'(DATA_W);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n_s, mosi_s;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s)
    );

    spi_state_e              state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]       rx_q, rx_d;
    logic [DATA_W-1:0]       tx_q, tx_d;
    logic [CMD_ADDR_W-1:0]   addr_q, addr_d;
    logic                    fetch_wait_q, fetch_wait_d;
    logic                    first_fall_q, first_fall_d;
    logic [ADDR_W-1:0]       w_addr_q, w_addr_d;
    logic [ADDR_W-1:0]       r_addr_q, r_addr_d;
    logic [DATA_W-1:0]       w_data_q, w_data_d;
    logic                    we_q, we_d;
    logic                    err_q, err_d;
    logic [CMD_BITS-1:0]     cmd_byte;
    logic [DATA_W-1:0]       rx_shifted;

    // Value the shift register holds once the bit arriving this cycle is included
    assign rx_shifted = {rx_q[DATA_W-2:0], mosi_s};
    assign cmd_byte   = rx_shifted[CMD_BITS-1:0];

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        fetch_wait_d = fetch_wait_q;
        first_fall_d = first_fall_q;
        w_addr_d     = w_addr_q;
        r_addr_d     = r_addr_q;
        w_data_d     = w_data_q;
        we_d         = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end

            StCmd: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (sclk_rise) begin
                    rx_d      = rx_shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_CMD_BIT) begin
                        addr_d    = cmd_byte[CMD_ADDR_HI:CMD_ADDR_LO];
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        if (cmd_byte[CMD_RSVD_HI:CMD_RSVD_LO] != '0) begin
                            err_d   = 1'b1;
                            state_d = StDone;
                        end else if (cmd_byte[CMD_W_BIT]) begin
                            state_d = StWrShift;
                        end else begin
                            r_addr_d     = ADDR_W'(cmd_byte[CMD_ADDR_HI:CMD_ADDR_LO]);
                            fetch_wait_d = 1'b0;
                            first_fall_d = 1'b0;
                            state_d      = StRdFetch;
                        end
                    end
                end
            end

            // One cycle for r_addr to reach memory, one for its read register
            StRdFetch: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (!fetch_wait_q) begin
                    fetch_wait_d = 1'b1;
                end else begin
                    tx_d    = r_data_i;
                    state_d = StRdShift;
                end
            end

            // First falling edge presents tx[MSB]; later ones shift
            StRdShift: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (sclk_fall) begin
                        if (!first_fall_q) begin
                            first_fall_d = 1'b1;
                        end else begin
                            tx_d = {tx_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_DATA_BIT) begin
                            state_d = StDone;
                        end
                    end
                end
            end

            // bit_cnt == DATA_W marks the commit cycle after the last bit; an abort
            // seen together with the last bit wins because it is checked first there.
            StWrShift: begin
                if (bit_cnt_q == WR_COMMIT) begin
                    w_addr_d = ADDR_W'(addr_q);
                    w_data_d = rx_q;
                    we_d     = 1'b1;
                    state_d  = StDone;
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (sclk_rise) begin
                    rx_d      = rx_shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            // Level check so a deselect is never missed
            StDone: begin
                if (cs_n_s) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            addr_q       <= '0;
            fetch_wait_q <= 1'b0;
            first_fall_q <= 1'b0;
            w_addr_q     <= '0;
            r_addr_q     <= '0;
            w_data_q     <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            fetch_wait_q <= fetch_wait_d;
            first_fall_q <= first_fall_d;
            w_addr_q     <= w_addr_d;
            r_addr_q     <= r_addr_d;
            w_data_q     <= w_data_d;
            we_q         <= we_d;
            err_q        <= err_d;
        end
    end

    assign miso = (state_q == StRdShift) && first_fall_q && !cs_n_s ? tx_q[DATA_W-1] : 1'b0;
    assign write_enable = we_q;
    assign w_addr       = w_addr_q;
    assign w_data       = w_data_q;
    assign r_addr       = r_addr_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge with a registered 16-word memory model.
module tb_spi_reg_bridge;

    localparam int HALF = 8;  // clk_in cycles per sclk half period

    logic        clk_in = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        write_enable;
    logic [7:0]  w_addr;
    logic [15:0] w_data;
    logic [7:0]  r_addr;
    logic [15:0] r_data;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    int          we_cnt      = 0;
    int          err_cnt     = 0;
    int          miso_hi_cnt = 0;
    logic [7:0]  last_waddr  = 8'h00;
    logic [15:0] last_wdata  = 16'h0000;
    logic [15:0] mem [16];

    always #5 clk_in = ~clk_in;

    spi_reg_bridge #(
        .DATA_W      (16),
        .ADDR_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .write_enable (write_enable),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .r_addr       (r_addr),
        .r_data_i     (r_data),
        .frame_err    (frame_err)
    );

    // Register file model: addresses 14/15 are read-only, 14 reads back 0x7FF0
    always @(posedge clk_in) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 14) ? 16'h7FF0 : 16'h0000;
            r_data <= 16'h0000;
        end else begin
            if (write_enable && w_addr < 8'd14) mem[w_addr[3:0]] <= w_data;
            r_data <= mem[r_addr[3:0]];
        end
    end

    always @(negedge clk_in) begin
        if (write_enable) begin
            we_cnt++;
            last_waddr = w_addr;
            last_wdata = w_data;
        end
        if (frame_err) err_cnt++;
        if (miso) miso_hi_cnt++;
    end

    // Clocks nbits out of tx (MSB aligned) and samples miso just before each rise
    task automatic spi_bits(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[31-i];
            repeat (HALF) @(negedge clk_in);
            rx[31-i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk_in);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
        @(negedge clk_in);
        cs_n = 1'b0;
        repeat (8) @(negedge clk_in);
        spi_bits(tx, nbits, rx);
        repeat (HALF) @(negedge clk_in);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk_in);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (4) @(negedge clk_in);
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
        total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", write_enable); end
        total++; if (w_addr !== 8'h00) begin bad++; $display("FAIL reset_waddr got=%h exp=00", w_addr); end
        total++; if (w_data !== 16'h0000) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", w_data); end
        total++; if (r_addr !== 8'h00) begin bad++; $display("FAIL reset_raddr got=%h exp=00", r_addr); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        reset = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic test_write_p();
        logic [31:0] rx;
        int we0 = we_cnt;
        int er0 = err_cnt;
        spi_frame(32'h8012_3400, 24, rx);
        total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL wr_p_pulses got=%0d exp=1", we_cnt - we0); end
        total++; if (last_waddr !== 8'h00) begin bad++; $display("FAIL wr_p_addr got=%h exp=00", last_waddr); end
        total++; if (last_wdata !== 16'h1234) begin bad++; $display("FAIL wr_p_data got=%h exp=1234", last_wdata); end
        total++; if (err_cnt - er0 !== 0) begin bad++; $display("FAIL wr_p_err got=%0d exp=0", err_cnt - er0); end
        total++; if (w_data !== 16'h1234) begin bad++; $display("FAIL wr_p_hold got=%h exp=1234", w_data); end
    endtask

    task automatic test_read_sp();
        logic [31:0] rx;
        int er0 = err_cnt;
        int we0;
        spi_frame(32'h83BE_EF00, 24, rx);
        we0 = we_cnt;
        spi_frame(32'h0300_0000, 24, rx);
        total++; if (r_addr !== 8'h03) begin bad++; $display("FAIL rd_sp_raddr got=%h exp=03", r_addr); end
        total++; if (rx[23:8] !== 16'hBEEF) begin bad++; $display("FAIL rd_sp_data got=%h exp=beef", rx[23:8]); end
        total++; if (we_cnt - we0 !== 0) begin bad++; $display("FAIL rd_sp_we got=%0d exp=0", we_cnt - we0); end
        total++; if (err_cnt - er0 !== 0) begin bad++; $display("FAIL rd_sp_err got=%0d exp=0", err_cnt - er0); end
    endtask

    task automatic test_read_pid_o();
        logic [31:0] rx;
        spi_frame(32'h0E00_0000, 24, rx);
        total++; if (r_addr !== 8'h0E) begin bad++; $display("FAIL rd_pido_raddr got=%h exp=0e", r_addr); end
        total++; if (rx[23:8] !== 16'h7FF0) begin bad++; $display("FAIL rd_pido_data got=%h exp=7ff0", rx[23:8]); end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        int we0 = we_cnt;
        int er0 = err_cnt;
        spi_frame(32'h81AA_AA00, 12, rx);
        total++; if (err_cnt - er0 !== 1) begin bad++; $display("FAIL abort_err got=%0d exp=1", err_cnt - er0); end
        total++; if (we_cnt - we0 !== 0) begin bad++; $display("FAIL abort_we got=%0d exp=0", we_cnt - we0); end
        spi_frame(32'h8155_5500, 24, rx);
        total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL abort_next_we got=%0d exp=1", we_cnt - we0); end
        total++; if (last_waddr !== 8'h01) begin bad++; $display("FAIL abort_next_addr got=%h exp=01", last_waddr); end
        total++; if (last_wdata !== 16'h5555) begin bad++; $display("FAIL abort_next_data got=%h exp=5555", last_wdata); end
        total++; if (err_cnt - er0 !== 1) begin bad++; $display("FAIL abort_next_err got=%0d exp=1", err_cnt - er0); end
    endtask

    task automatic test_reserved();
        logic [31:0] rx;
        int we0 = we_cnt;
        int er0 = err_cnt;
        int mh0 = miso_hi_cnt;
        spi_frame(32'hC1FF_FF00, 24, rx);
        total++; if (err_cnt - er0 !== 1) begin bad++; $display("FAIL rsvd_err got=%0d exp=1", err_cnt - er0); end
        total++; if (we_cnt - we0 !== 0) begin bad++; $display("FAIL rsvd_we got=%0d exp=0", we_cnt - we0); end
        total++; if (miso_hi_cnt - mh0 !== 0) begin bad++; $display("FAIL rsvd_miso got=%0d exp=0", miso_hi_cnt - mh0); end
    endtask

    // Write to a read-only address is still strobed; two surplus bits are ignored
    task automatic test_write_high_extra();
        logic [31:0] rx;
        int we0 = we_cnt;
        int er0 = err_cnt;
        spi_frame(32'h8F00_FFC0, 26, rx);
        total++; if (we_cnt - we0 !== 1) begin bad++; $display("FAIL wr15_we got=%0d exp=1", we_cnt - we0); end
        total++; if (last_waddr !== 8'h0F) begin bad++; $display("FAIL wr15_addr got=%h exp=0f", last_waddr); end
        total++; if (last_wdata !== 16'h00FF) begin bad++; $display("FAIL wr15_data got=%h exp=00ff", last_wdata); end
        total++; if (err_cnt - er0 !== 0) begin bad++; $display("FAIL wr15_err got=%0d exp=0", err_cnt - er0); end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rx;
        int er0;
        @(negedge clk_in);
        cs_n = 1'b0;
        repeat (8) @(negedge clk_in);
        spi_bits(32'h0300_0000, 14, rx);
        reset = 1'b0;
        #1;
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL rstmid_miso got=%b exp=0", miso); end
        total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%b exp=0", write_enable); end
        total++; if (w_addr !== 8'h00) begin bad++; $display("FAIL rstmid_waddr got=%h exp=00", w_addr); end
        total++; if (w_data !== 16'h0000) begin bad++; $display("FAIL rstmid_wdata got=%h exp=0000", w_data); end
        total++; if (r_addr !== 8'h00) begin bad++; $display("FAIL rstmid_raddr got=%h exp=00", r_addr); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b exp=0", frame_err); end
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk_in);
        reset = 1'b1;
        repeat (8) @(negedge clk_in);
        er0 = err_cnt;
        spi_frame(32'h8213_5700, 24, rx);
        spi_frame(32'h0200_0000, 24, rx);
        total++; if (r_addr !== 8'h02) begin bad++; $display("FAIL rstmid_rd_raddr got=%h exp=02", r_addr); end
        total++; if (rx[23:8] !== 16'h1357) begin bad++; $display("FAIL rstmid_rd_data got=%h exp=1357", rx[23:8]); end
        total++; if (err_cnt - er0 !== 0) begin bad++; $display("FAIL rstmid_rd_err got=%0d exp=0", err_cnt - er0); end
    endtask

    initial begin
        test_reset();
        test_write_p();
        test_read_sp();
        test_read_pid_o();
        test_abort();
        test_reserved();
        test_write_high_extra();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
